// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmitter that serialises DATA_BITS-wide bytes onto txd_o.
// Before each frame it asserts tx_rts_n_o and waits for tx_cts_n_i low with tx_enable_i
// high. Frame config (baud divider, parity enable/odd, two stop bits) is latched when a
// byte is taken, so later input changes do not affect the frame in flight.
//
// Optional feature macro: UART_TX_FIFO_EN adds a FIFO_DEPTH-entry input FIFO.
//
// Ports:
//   tck           clock
//   rst           synchronous reset, active-high
//   data_i        byte to transmit
//   valid_i       data_i valid
//   ready_o       transfer happens on valid_i & ready_o
//   baud_div_i    bit period minus one, in tck cycles
//   parity_en_i   append parity bit
//   parity_odd_i  1 = odd parity, 0 = even
//   stop2_i       1 = two stop bits
//   tx_enable_i   line enable from flow control
//   tx_rts_n_o    request to send, active-low
//   tx_cts_n_i    clear to send, active-low
//   txd_o         serial line, idle high (registered)
//   busy_o        frame in progress (or FIFO holding data)
module uart_tx_engine #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 tck,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DIV_W-1:0]     baud_div_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 stop2_i,
  input  logic                 tx_enable_i,
  output logic                 tx_rts_n_o,
  input  logic                 tx_cts_n_i,
  output logic                 txd_o,
  output logic                 busy_o
);

  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    StIdle, StReq, StStart, StData, StParity, StStop
  } state_e;

  state_e                 state_q, state_d;
  logic                   txd_q, txd_d;
  logic                   rts_n_q, rts_n_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;
  logic                   stop2_q, stop2_d;

  // Frame source: either the host port directly or the head of the FIFO.
  logic                   load;
  logic [DATA_BITS-1:0]   load_data;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic                 fifo_full, fifo_empty, push;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign load       = (state_q == StIdle) && !fifo_empty;
  assign load_data  = mem_q[rd_ptr_q[AW-1:0]];
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign ready_o    = !rst && (!fifo_full || load);
  assign push       = valid_i && ready_o;
  assign busy_o     = (state_q != StIdle) || !fifo_empty;

  always_ff @(posedge tck) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (load) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge tck) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
`else
  assign ready_o   = !rst && (state_q == StIdle);
  assign load      = valid_i && ready_o;
  assign load_data = data_i;
  assign busy_o    = (state_q != StIdle);
`endif

  logic            bit_done;
  logic            parity_bit;
  logic [IdxW-1:0] idx_nxt;

  assign bit_done   = (cnt_q == div_q);
  assign parity_bit = (^data_q) ^ par_odd_q;
  assign idx_nxt    = idx_q + IdxW'(1);

  always_comb begin
    state_d    = state_q;
    txd_d      = txd_q;
    rts_n_d    = rts_n_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    data_d     = data_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;

    unique case (state_q)
      StIdle: begin
        if (load) begin
          data_d    = load_data;
          div_d     = baud_div_i;
          par_en_d  = parity_en_i;
          par_odd_d = parity_odd_i;
          stop2_d   = stop2_i;
          rts_n_d   = 1'b0;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (!tx_cts_n_i && tx_enable_i) begin
          state_d = StStart;
          txd_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (bit_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StData;
          txd_d   = data_q[0];
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == IdxW'(DATA_BITS - 1)) begin
            if (par_en_q) begin
              state_d = StParity;
              txd_d   = parity_bit;
            end else begin
              state_d    = StStop;
              txd_d      = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            idx_d = idx_nxt;
            txd_d = data_q[idx_nxt];
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StParity: begin
        if (bit_done) begin
          cnt_d      = '0;
          state_d    = StStop;
          txd_d      = 1'b1;
          stop_idx_d = 1'b0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StStop: begin
        if (bit_done) begin
          cnt_d = '0;
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d = StIdle;
            rts_n_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
        rts_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge tck) begin
    if (rst) begin
      state_q    <= StIdle;
      txd_q      <= 1'b1;
      rts_n_q    <= 1'b1;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      txd_q      <= txd_d;
      rts_n_q    <= rts_n_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      data_q     <= data_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
    end
  end

  assign txd_o      = txd_q;
  assign tx_rts_n_o = rts_n_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;

  logic        tck = 1'b0;
  logic        rst;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] baud_div_i;
  logic        parity_en_i;
  logic        parity_odd_i;
  logic        stop2_i;
  logic        tx_enable_i;
  logic        tx_rts_n_o;
  logic        tx_cts_n_i;
  logic        txd_o;
  logic        busy_o;

  uart_tx_engine #(
    .DATA_BITS (8),
    .DIV_W     (16),
    .FIFO_DEPTH(4)
  ) dut (
    .tck         (tck),
    .rst         (rst),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .baud_div_i  (baud_div_i),
    .parity_en_i (parity_en_i),
    .parity_odd_i(parity_odd_i),
    .stop2_i     (stop2_i),
    .tx_enable_i (tx_enable_i),
    .tx_rts_n_o  (tx_rts_n_o),
    .tx_cts_n_i  (tx_cts_n_i),
    .txd_o       (txd_o),
    .busy_o      (busy_o)
  );

  always #5 tck = ~tck;

  int n_vec = 0;
  int n_err = 0;

  // seq holds the line levels in transmission order, leftmost first: start, data LSB
  // first, optional parity, stop bit(s).
  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic        pen;
    logic        podd;
    logic        s2;
    logic [0:11] seq;
    int          nbits;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hand one byte to the engine; returns with the engine in REQ.
  task automatic accept(input vec_t v);
    data_i       = v.data;
    baud_div_i   = v.div;
    parity_en_i  = v.pen;
    parity_odd_i = v.podd;
    stop2_i      = v.s2;
    valid_i      = 1'b1;
    tick();
    valid_i = 1'b0;
`ifdef UART_TX_FIFO_EN
    tick();
`endif
    // Config changes after the latch must not affect the frame.
    data_i       = ~v.data;
    baud_div_i   = 16'd5;
    parity_en_i  = ~v.pen;
    parity_odd_i = ~v.podd;
    stop2_i      = ~v.s2;
  endtask

  task automatic send_frame(input int id, input vec_t v, input int drop_at);
    int cyc;
    chk($sformatf("v%0d idle_ready", id), ready_o, 1);
    accept(v);
    chk($sformatf("v%0d req_rts", id), tx_rts_n_o, 0);
    chk($sformatf("v%0d req_txd", id), txd_o, 1);
    chk($sformatf("v%0d req_busy", id), busy_o, 1);
    cyc = 0;
    for (int i = 0; i < v.nbits; i++) begin
      for (int c = 0; c <= int'(v.div); c++) begin
        tick();
        chk($sformatf("v%0d bit%0d cyc%0d txd", id, i, c), txd_o, v.seq[i]);
        chk($sformatf("v%0d bit%0d cyc%0d rts", id, i, c), tx_rts_n_o, 0);
        if (cyc == drop_at) begin
          tx_cts_n_i  = 1'b1;
          tx_enable_i = 1'b0;
        end
        cyc++;
      end
    end
    tick();
    chk($sformatf("v%0d end_rts", id), tx_rts_n_o, 1);
    chk($sformatf("v%0d end_busy", id), busy_o, 0);
    chk($sformatf("v%0d end_txd", id), txd_o, 1);
    tx_cts_n_i  = 1'b0;
    tx_enable_i = 1'b1;
  endtask

`ifdef UART_TX_FIFO_EN
  logic [7:0] fifo_bytes[5];
`endif

  initial begin
    vecs[0] = '{8'h55, 16'd3, 1'b0, 1'b0, 1'b0, 12'b010101010100, 10};
    vecs[1] = '{8'hA7, 16'd0, 1'b1, 1'b0, 1'b1, 12'b011100101111, 12};
    vecs[2] = '{8'h0F, 16'd1, 1'b1, 1'b1, 1'b0, 12'b011110000110, 11};
    vecs[3] = '{8'h80, 16'd2, 1'b1, 1'b0, 1'b1, 12'b000000001111, 12};
    vecs[4] = '{8'h00, 16'd0, 1'b1, 1'b1, 1'b0, 12'b000000000110, 11};
    vecs[5] = '{8'hFF, 16'd0, 1'b0, 1'b0, 1'b1, 12'b011111111110, 11};

    rst          = 1'b1;
    data_i       = '0;
    valid_i      = 1'b0;
    baud_div_i   = '0;
    parity_en_i  = 1'b0;
    parity_odd_i = 1'b0;
    stop2_i      = 1'b0;
    tx_enable_i  = 1'b1;
    tx_cts_n_i   = 1'b0;

    // Reset state.
    tick();
    chk("rst txd", txd_o, 1);
    chk("rst rts", tx_rts_n_o, 1);
    chk("rst busy", busy_o, 0);
    chk("rst ready", ready_o, 0);
    rst = 1'b0;
    #1;
    chk("post_rst ready", ready_o, 1);
    tick();

    // Table-driven frames; vector 2 drops cts/enable mid-DATA.
    for (int k = 0; k < 6; k++) begin
      send_frame(k, vecs[k], (k == 2) ? 5 : -1);
    end

    // Held in REQ: first with cts_n high, then with enable low.
    tx_cts_n_i = 1'b1;
    accept(vecs[1]);
    for (int c = 0; c < 20; c++) begin
      if (c == 10) begin
        tx_cts_n_i  = 1'b0;
        tx_enable_i = 1'b0;
      end
      tick();
      chk($sformatf("hold%0d rts", c), tx_rts_n_o, 0);
      chk($sformatf("hold%0d txd", c), txd_o, 1);
      chk($sformatf("hold%0d busy", c), busy_o, 1);
    end
    tx_enable_i = 1'b1;
    tick();
    chk("hold start", txd_o, 0);
    for (int i = 1; i < vecs[1].nbits; i++) begin
      tick();
      chk($sformatf("hold bit%0d", i), txd_o, vecs[1].seq[i]);
    end
    tick();
    chk("hold end_rts", tx_rts_n_o, 1);
    chk("hold end_busy", busy_o, 0);

    // Reset in the middle of DATA bit 3 (a 0 bit of 0x55).
    accept(vecs[0]);
    for (int c = 0; c < 18; c++) tick();
    chk("midrst pre txd", txd_o, 0);
    rst = 1'b1;
    tick();
    chk("midrst txd", txd_o, 1);
    chk("midrst rts", tx_rts_n_o, 1);
    chk("midrst busy", busy_o, 0);
    chk("midrst ready", ready_o, 0);
    rst = 1'b0;
    #1;
    chk("midrst ready_after", ready_o, 1);
    tick();
    chk("midrst idle txd", txd_o, 1);
    chk("midrst idle rts", tx_rts_n_o, 1);

`ifdef UART_TX_FIFO_EN
    fifo_bytes[0] = 8'h3C;
    fifo_bytes[1] = 8'h81;
    fifo_bytes[2] = 8'hE4;
    fifo_bytes[3] = 8'h5A;
    fifo_bytes[4] = 8'h07;
    baud_div_i   = '0;
    parity_en_i  = 1'b0;
    parity_odd_i = 1'b0;
    stop2_i      = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          data_i  = fifo_bytes[k];
          valid_i = 1'b1;
          chk($sformatf("fifo push%0d ready", k), ready_o, 1);
          tick();
        end
        valid_i = 1'b0;
        chk("fifo full ready", ready_o, 0);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          logic [7:0] got;
          int w;
          w = 0;
          while (txd_o !== 1'b0 && w < 100) begin
            tick();
            w++;
          end
          chk($sformatf("fifo f%0d start_seen", k), (w < 100), 1);
          for (int b = 0; b < 8; b++) begin
            tick();
            got[b] = txd_o;
          end
          chk($sformatf("fifo f%0d data", k), got, fifo_bytes[k]);
          tick();
          chk($sformatf("fifo f%0d stop", k), txd_o, 1);
          tick();
          chk($sformatf("fifo f%0d idle_rts", k), tx_rts_n_o, 1);
        end
      end
    join
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
